// File: rtl/des_key_sched_ctrl.sv
// des_key_sched_ctrl: iterative DES key-schedule sequencer.
// Latches a post-PC-1 key on start and steps the 28-bit C/D halves through
// the 16-round rotation schedule, one round per cycle the core accepts.
// Encrypt rotates left starting from a 1-bit rotation at round 0. Decrypt
// starts unrotated and rotates right through the table in reverse order.
module des_key_sched_ctrl #(
  parameter int ROUNDS = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             decrypt,
  input  logic [55:0]      key_in,
  input  logic             core_stall,
  output logic             ready,
  output logic             load_block,
  output logic             round_valid,
  output logic [3:0]       round_idx,
  output logic [55:0]      round_cd,
  output logic             last_round,
  output logic             done,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

  state_t      state_r;
  logic        dec_r;
  logic [4:0]  enc_k_s;
  logic [4:0]  dec_k_s;
  logic [27:0] c_next_s;
  logic [27:0] d_next_s;
  logic [3:0]  idx_next_s;

  // DES shift table, 1-based round number k = 1..16.
  function automatic logic [1:0] shift_amt(input logic [4:0] k);
    logic [1:0] amt;
    case (k)
      5'd1, 5'd2, 5'd9, 5'd16: amt = 2'd1;
      default:                 amt = 2'd2;
    endcase
    return amt;
  endfunction

  // 28-bit wrap-around rotate left by 1 or 2.
  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] r;
    case (n)
      2'd1:    r = {x[26:0], x[27]};
      2'd2:    r = {x[25:0], x[27:26]};
      default: r = x;
    endcase
    return r;
  endfunction

  // 28-bit wrap-around rotate right by 1 or 2.
  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] r;
    case (n)
      2'd1:    r = {x[0], x[27:1]};
      2'd2:    r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

  // Next-round C/D: moving from round i to i+1 encrypt uses table entry i+2,
  // decrypt uses entry 16-i (i.e. 17-(i+1)).
  always_comb begin
    idx_next_s = round_idx + 4'd1;
    enc_k_s    = {1'b0, round_idx} + 5'd2;
    dec_k_s    = 5'd16 - {1'b0, round_idx};
    if (dec_r) begin
      c_next_s = rotr28(round_cd[55:28], shift_amt(dec_k_s));
      d_next_s = rotr28(round_cd[27:0],  shift_amt(dec_k_s));
    end else begin
      c_next_s = rotl28(round_cd[55:28], shift_amt(enc_k_s));
      d_next_s = rotl28(round_cd[27:0],  shift_amt(enc_k_s));
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      dec_r       <= 1'b0;
      ready       <= 1'b1;
      load_block  <= 1'b0;
      round_valid <= 1'b0;
      round_idx   <= 4'd0;
      round_cd    <= 56'd0;
      last_round  <= 1'b0;
      done        <= 1'b0;
      op_count    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dec_r       <= decrypt;
            round_idx   <= 4'd0;
            round_valid <= 1'b1;
            load_block  <= 1'b1;
            last_round  <= (LAST_IDX == 4'd0);
            ready       <= 1'b0;
            state_r     <= ROUND;
            if (decrypt) begin
              round_cd <= key_in;
            end else begin
              round_cd <= {rotl28(key_in[55:28], 2'd1), rotl28(key_in[27:0], 2'd1)};
            end
          end else begin
            ready <= 1'b1;
          end
        end
        ROUND: begin
          // The block-load pulse covers only the first presentation of round 0.
          load_block <= 1'b0;
          if (!core_stall) begin
            if (round_idx == LAST_IDX) begin
              state_r     <= DONE;
              round_valid <= 1'b0;
              last_round  <= 1'b0;
              done        <= 1'b1;
              if (op_count != {CNT_W{1'b1}}) begin
                op_count <= op_count + CNT_W'(1);
              end else begin
                op_count <= op_count;
              end
            end else begin
              round_idx  <= idx_next_s;
              round_cd   <= {c_next_s, d_next_s};
              last_round <= (idx_next_s == LAST_IDX);
            end
          end else begin
            round_idx <= round_idx;
            round_cd  <= round_cd;
          end
        end
        DONE: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          ready       <= 1'b1;
          done        <= 1'b0;
          load_block  <= 1'b0;
          round_valid <= 1'b0;
          last_round  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Directed self-checking bench for des_key_sched_ctrl.
module tb_des_key_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic [55:0] key_in;
  logic        core_stall;
  logic        ready;
  logic        load_block;
  logic        round_valid;
  logic [3:0]  round_idx;
  logic [55:0] round_cd;
  logic        last_round;
  logic        done;
  logic [15:0] op_count;

  int n_assert = 0;
  int n_fail   = 0;

  des_key_sched_ctrl #(.ROUNDS(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key_in(key_in),
    .core_stall(core_stall), .ready(ready), .load_block(load_block),
    .round_valid(round_valid), .round_idx(round_idx), .round_cd(round_cd),
    .last_round(last_round), .done(done), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] cd2(input logic [27:0] h);
    return {h, h};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; key_in = 56'd0; core_stall = 1'b0;
    tick(2);
    rst = 1'b0;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_valid", 64'(round_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_load", 64'(load_block), 64'd0);
    chk("rst_idx", 64'(round_idx), 64'd0);
    chk("rst_cd", 64'(round_cd), 64'd0);
    chk("rst_cnt", 64'(op_count), 64'd0);

    // Encrypt, key {1,1}, no stall
    key_in = cd2(28'h0000001); decrypt = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0; key_in = 56'hABCDEF01234567; decrypt = 1'b1;
    chk("enc_r0_valid", 64'(round_valid), 64'd1);
    chk("enc_r0_idx", 64'(round_idx), 64'd0);
    chk("enc_r0_cd", 64'(round_cd), 64'(cd2(28'h0000002)));
    chk("enc_r0_load", 64'(load_block), 64'd1);
    chk("enc_r0_ready", 64'(ready), 64'd0);
    tick(1);
    chk("enc_r1_cd", 64'(round_cd), 64'(cd2(28'h0000004)));
    chk("enc_r1_load", 64'(load_block), 64'd0);
    tick(1);
    chk("enc_r2_cd", 64'(round_cd), 64'(cd2(28'h0000010)));
    tick(6);
    chk("enc_r8_idx", 64'(round_idx), 64'd8);
    chk("enc_r8_cd", 64'(round_cd), 64'(cd2(28'h0008000)));
    tick(6);
    chk("enc_r14_last", 64'(last_round), 64'd0);
    tick(1);
    chk("enc_r15_idx", 64'(round_idx), 64'd15);
    chk("enc_r15_cd", 64'(round_cd), 64'(cd2(28'h0000001)));
    chk("enc_r15_last", 64'(last_round), 64'd1);
    chk("enc_c16_done", 64'(done), 64'd0);
    tick(1);
    chk("enc_c17_done", 64'(done), 64'd1);
    chk("enc_c17_valid", 64'(round_valid), 64'd0);
    chk("enc_c17_ready", 64'(ready), 64'd0);
    chk("enc_c17_cnt", 64'(op_count), 64'd1);
    chk("enc_c17_cdhold", 64'(round_cd), 64'(cd2(28'h0000001)));
    tick(1);
    chk("enc_c18_ready", 64'(ready), 64'd1);
    chk("enc_c18_done", 64'(done), 64'd0);

    // Decrypt, same key
    key_in = cd2(28'h0000001); decrypt = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0; decrypt = 1'b0;
    chk("dec_r0_cd", 64'(round_cd), 64'(cd2(28'h0000001)));
    chk("dec_r0_load", 64'(load_block), 64'd1);
    tick(1);
    chk("dec_r1_cd", 64'(round_cd), 64'(cd2(28'h8000000)));
    chk("dec_r1_load", 64'(load_block), 64'd0);
    tick(1);
    chk("dec_r2_cd", 64'(round_cd), 64'(cd2(28'h2000000)));
    tick(13);
    chk("dec_r15_idx", 64'(round_idx), 64'd15);
    chk("dec_r15_cd", 64'(round_cd), 64'(cd2(28'h0000002)));
    tick(1);
    chk("dec_done", 64'(done), 64'd1);
    chk("dec_cnt", 64'(op_count), 64'd2);
    tick(1);

    // Encrypt with a 3-cycle stall at round 5; done moves to cycle 20
    key_in = cd2(28'h0000001); decrypt = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    chk("stl_r5_idx", 64'(round_idx), 64'd5);
    chk("stl_r5_cd", 64'(round_cd), 64'(cd2(28'h0000400)));
    core_stall = 1'b1;
    tick(3);
    core_stall = 1'b0;
    chk("stl_hold_idx", 64'(round_idx), 64'd5);
    chk("stl_hold_cd", 64'(round_cd), 64'(cd2(28'h0000400)));
    chk("stl_hold_load", 64'(load_block), 64'd0);
    chk("stl_hold_valid", 64'(round_valid), 64'd1);
    tick(1);
    chk("stl_r6_idx", 64'(round_idx), 64'd6);
    tick(9);
    chk("stl_c19_idx", 64'(round_idx), 64'd15);
    chk("stl_c19_done", 64'(done), 64'd0);
    tick(1);
    chk("stl_c20_done", 64'(done), 64'd1);
    chk("stl_cnt", 64'(op_count), 64'd3);
    tick(1);

    // Start pulses at cycles 4 and 10 during an operation are ignored
    key_in = cd2(28'h0000001); decrypt = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    start = 1'b1; key_in = {56{1'b1}}; decrypt = 1'b1;
    tick(1);
    start = 1'b0;
    chk("ign_r4_idx", 64'(round_idx), 64'd4);
    chk("ign_r4_cd", 64'(round_cd), 64'(cd2(28'h0000100)));
    tick(5);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("ign_r10_idx", 64'(round_idx), 64'd10);
    chk("ign_r10_cd", 64'(round_cd), 64'(cd2(28'h0080000)));
    tick(5);
    chk("ign_r15_cd", 64'(round_cd), 64'(cd2(28'h0000001)));
    tick(1);
    chk("ign_done", 64'(done), 64'd1);
    chk("ign_cnt", 64'(op_count), 64'd4);
    tick(1);
    chk("ign_c18_done", 64'(done), 64'd0);
    tick(1);
    chk("ign_c19_done", 64'(done), 64'd0);
    chk("ign_c19_ready", 64'(ready), 64'd1);
    chk("ign_c19_cnt", 64'(op_count), 64'd4);

    // Reset mid-operation at round 7
    key_in = cd2(28'h0000001); decrypt = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(7);
    chk("mrst_r7_idx", 64'(round_idx), 64'd7);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mrst_ready", 64'(ready), 64'd1);
    chk("mrst_valid", 64'(round_valid), 64'd0);
    chk("mrst_cd", 64'(round_cd), 64'd0);
    chk("mrst_cnt", 64'(op_count), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    tick(1);
    chk("mrst_done2", 64'(done), 64'd0);
    chk("mrst_valid2", 64'(round_valid), 64'd0);

    // All-ones key, encrypt: constant every round
    key_in = {56{1'b1}}; decrypt = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int r = 0; r < 16; r++) begin
      chk($sformatf("ones_r%0d_cd", r), 64'(round_cd), 64'({56{1'b1}}));
      tick(1);
    end
    chk("ones_done", 64'(done), 64'd1);
    chk("ones_cnt", 64'(op_count), 64'd1);
    tick(1);
    chk("b2b_ready", 64'(ready), 64'd1);

    // Back-to-back start on the cycle ready rises, all-zeros key, decrypt
    key_in = 56'd0; decrypt = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("zero_r0_valid", 64'(round_valid), 64'd1);
    chk("zero_r0_load", 64'(load_block), 64'd1);
    for (int r = 0; r < 16; r++) begin
      chk($sformatf("zero_r%0d_idx", r), 64'(round_idx), 64'(r));
      chk($sformatf("zero_r%0d_cd", r), 64'(round_cd), 64'd0);
      tick(1);
    end
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_cnt", 64'(op_count), 64'd2);
    tick(1);
    chk("zero_ready", 64'(ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
